// File: rtl/bcrypt_core_out_deser.sv
// Output deserializer for one bcrypt core: requests a finished result, captures the
// MSB-first serial packet behind its header bit, and replays it as 32-bit valid/ready words.
module bcrypt_core_out_deser #(
  parameter int N_WORDS     = 8,
  parameter int HDR_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        core_empty,
  input  logic        core_dout,
  output logic        core_rd_en,
  output logic [31:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        word_last,
  output logic        busy,
  output logic        err_timeout
);

  localparam int NBITS = N_WORDS * 32;
  localparam int BCW   = $clog2(NBITS);
  localparam int IW    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  localparam logic [BCW-1:0] BIT_LAST = BCW'(NBITS - 1);
  localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(N_WORDS - 1);
  localparam logic [IW-1:0]  IDX_PEN  = IW'(N_WORDS - 2);
  localparam logic [IW-1:0]  IDX_ONE  = IW'(1);
  localparam logic [15:0]    TMO_LAST = 16'(HDR_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_WAIT_HDR = 3'd2,
    S_SHIFT    = 3'd3,
    S_OUT      = 3'd4
  } state_t;

  state_t           state_q;
  logic [15:0]      tmo_cnt_q;
  logic [BCW-1:0]   bit_cnt_q;
  logic [IW-1:0]    word_idx_q;
  logic [NBITS-1:0] buf_q;
  logic             rd_en_q;
  logic [31:0]      word_q;
  logic             valid_q;
  logic             last_q;
  logic             busy_q;
  logic             err_q;

  // Buffer value after capturing this cycle's serial bit; also feeds word 0 on the final bit.
  logic [NBITS-1:0] buf_d;
  assign buf_d = {buf_q[NBITS-2:0], core_dout};

  // Transfer FSM; every output is a register updated alongside the state.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tmo_cnt_q  <= 16'd0;
      bit_cnt_q  <= '0;
      word_idx_q <= '0;
      buf_q      <= '0;
      rd_en_q    <= 1'b0;
      word_q     <= 32'd0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!core_empty) begin
            state_q <= S_REQ;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            rd_en_q <= 1'b0;
          end
        end
        S_REQ: begin
          rd_en_q   <= 1'b0;
          tmo_cnt_q <= 16'd0;
          state_q   <= S_WAIT_HDR;
        end
        // A header on the limiting cycle wins over the timeout.
        S_WAIT_HDR: begin
          if (core_dout) begin
            state_q   <= S_SHIFT;
            bit_cnt_q <= '0;
          end else if (tmo_cnt_q == TMO_LAST) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
            err_q     <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end
        S_SHIFT: begin
          buf_q     <= buf_d;
          bit_cnt_q <= bit_cnt_q + BIT_ONE;
          if (bit_cnt_q == BIT_LAST) begin
            state_q    <= S_OUT;
            word_q     <= buf_d[NBITS-1 -: 32];
            word_idx_q <= '0;
            valid_q    <= 1'b1;
            last_q     <= (IDX_LAST == '0);
          end else begin
            state_q <= S_SHIFT;
          end
        end
        // The buffer shifts up a word per handshake so the next word always sits just below the top.
        S_OUT: begin
          if (word_ready) begin
            if (word_idx_q == IDX_LAST) begin
              valid_q    <= 1'b0;
              last_q     <= 1'b0;
              word_idx_q <= '0;
              busy_q     <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              buf_q      <= {buf_q[NBITS-33:0], 32'd0};
              word_q     <= buf_q[NBITS-33 -: 32];
              word_idx_q <= word_idx_q + IDX_ONE;
              last_q     <= (word_idx_q == IDX_PEN);
            end
          end else begin
            state_q <= S_OUT;
          end
        end
        default: begin
          state_q <= S_IDLE;
          rd_en_q <= 1'b0;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign core_rd_en  = rd_en_q;
  assign word_out    = word_q;
  assign word_valid  = valid_q;
  assign word_last   = last_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_bcrypt_core_out_deser.sv
// Directed bench: a behavioural core drives serial packets, a queue scoreboard checks the words.
module tb_bcrypt_core_out_deser;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_empty = 1'b1;
  logic        core_dout = 1'b0;
  logic        word_ready = 1'b0;
  logic        core_rd_en;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_last;
  logic        busy;
  logic        err_timeout;

  bcrypt_core_out_deser #(.N_WORDS(8), .HDR_TIMEOUT(255)) dut (
    .CLK(CLK), .rst_n(rst_n), .core_empty(core_empty), .core_dout(core_dout),
    .core_rd_en(core_rd_en), .word_out(word_out), .word_valid(word_valid),
    .word_ready(word_ready), .word_last(word_last), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;
  int rd_pulses = 0;
  logic [31:0] sb_q[$];
  logic [31:0] pkt [8] = '{32'h00000001, 32'h00000002, 32'hDEADBEEF, 32'h01234567,
                           32'h89ABCDEF, 32'hFFFFFFFF, 32'h00000000, 32'hA5A5A5A5};

  always @(negedge CLK) if (core_rd_en) rd_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_rd();
    int waited = 0;
    core_empty = 1'b0;
    do begin @(negedge CLK); waited++; end while (!core_rd_en && waited < 20);
    check("rd_en_latency", waited, 32'd1);
  endtask

  task automatic send_packet(input int hdr_delay, input int nbits, input bit hold_empty);
    wait_rd();
    core_empty = hold_empty ? 1'b0 : 1'b1;
    core_dout  = 1'b0;
    for (int i = 0; i <= hdr_delay; i++) begin
      @(negedge CLK);
      if (i == 0) check("rd_en_pulse", 32'(core_rd_en), 32'd0);
      core_dout = (i == hdr_delay);
    end
    if (nbits == 256) for (int w = 0; w < 8; w++) sb_q.push_back(pkt[w]);
    for (int b = 0; b < nbits; b++) begin
      @(negedge CLK);
      core_dout = pkt[b/32][31 - (b % 32)];
    end
  endtask

  task automatic receive(input bit bp);
    int hs = 0;
    int cyc = 0;
    logic [31:0] exp;
    while (hs < 8 && cyc < 100) begin
      @(negedge CLK);
      core_dout = 1'b0;
      check("word_valid", 32'(word_valid), 32'd1);
      if (word_valid) begin
        exp = (sb_q.size() > 0) ? sb_q[0] : 32'hxxxxxxxx;
        check("word_out", word_out, exp);
        check("word_last", 32'(word_last), 32'(hs == 7));
      end
      word_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (word_valid && word_ready) begin
        void'(sb_q.pop_front());
        hs++;
      end
      cyc++;
    end
    check("handshakes", hs, 32'd8);
    @(negedge CLK);
    word_ready = 1'b0;
    check("valid_after", 32'(word_valid), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("no_early_req", 32'(core_rd_en), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    rst_n = 1'b0;
    @(negedge CLK);
    rst_n = 1'b1;
  endtask

  initial begin
    int p0;
    #1;
    check("rst_rd_en", 32'(core_rd_en), 32'd0);
    check("rst_word_out", word_out, 32'd0);
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_last", 32'(word_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);

    // Single packet with ready held high.
    p0 = rd_pulses;
    send_packet(3, 256, 1'b0);
    receive(1'b0);
    #1;
    check("one_rd_pulse", rd_pulses - p0, 32'd1);

    // Backpressure with ready 1,0,0,1.
    send_packet(5, 256, 1'b0);
    receive(1'b1);

    // Back-to-back with core_empty held low.
    send_packet(3, 256, 1'b1);
    receive(1'b0);
    send_packet(2, 256, 1'b0);
    receive(1'b0);

    // Timeout after 255 header-less cycles, then a normal packet.
    wait_rd();
    core_empty = 1'b1;
    core_dout  = 1'b0;
    repeat (255) begin @(negedge CLK); core_dout = 1'b0; end
    check("err_before_limit", 32'(err_timeout), 32'd0);
    @(negedge CLK);
    check("err_set", 32'(err_timeout), 32'd1);
    check("busy_after_tmo", 32'(busy), 32'd0);
    send_packet(3, 256, 1'b0);
    receive(1'b0);
    check("err_sticky", 32'(err_timeout), 32'd1);

    // Header on the limiting cycle is accepted.
    pulse_reset();
    check("err_cleared", 32'(err_timeout), 32'd0);
    send_packet(254, 256, 1'b0);
    receive(1'b0);
    check("err_hdr_on_limit", 32'(err_timeout), 32'd0);

    // Reset during SHIFT discards the partial packet.
    send_packet(3, 100, 1'b0);
    @(negedge CLK);
    check("busy_in_shift", 32'(busy), 32'd1);
    rst_n = 1'b0;
    core_dout = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(word_valid), 32'd0);
    check("mid_rst_word", word_out, 32'd0);
    check("mid_rst_rd_en", 32'(core_rd_en), 32'd0);
    @(negedge CLK);
    rst_n = 1'b1;
    p0 = rd_pulses;
    repeat (10) @(negedge CLK);
    #1;
    check("no_req_after_rst", rd_pulses - p0, 32'd0);
    check("idle_after_rst", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
